// File: rtl/hwpe_ctrl_job_queue.sv
// Multi-context job dispatcher for HWPE control. Cores reserve a slot, program it and commit it.
// Committed jobs run on the engine in FIFO order, and their events go back to the committing core.
module hwpe_ctrl_job_queue #(
    parameter int unsigned N_CORES     = 4,
    parameter int unsigned N_CONTEXT   = 3,
    parameter int unsigned N_EVT       = 4,
    parameter int unsigned RSV_TIMEOUT = 256,
    parameter int unsigned START_GAP   = 1,
    localparam int unsigned CW = (N_CORES > 1) ? $clog2(N_CORES) : 1,
    localparam int unsigned XW = (N_CONTEXT > 1) ? $clog2(N_CONTEXT) : 1,
    localparam int unsigned PW = $clog2(N_CONTEXT + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic                            acq_i,
    input  logic [CW-1:0]                   acq_core_i,
    output logic                            acq_valid_o,
    output logic                            acq_ok_o,
    output logic [XW-1:0]                   acq_ctx_o,
    input  logic                            commit_i,
    input  logic [CW-1:0]                   commit_core_i,
    output logic                            commit_err_o,
    output logic [XW-1:0]                   rsv_ctx_o,
    output logic                            rsv_held_o,
    output logic                            start_o,
    output logic [XW-1:0]                   run_ctx_o,
    output logic                            busy_o,
    input  logic                            done_i,
    input  logic [N_EVT-1:0]                evt_i,
    output logic [N_CORES-1:0][N_EVT:0]     evt_o,
    output logic [PW-1:0]                   pending_o,
    output logic                            full_o
);

    localparam int unsigned TW       = (RSV_TIMEOUT > 0) ? $clog2(RSV_TIMEOUT + 1) : 1;
    localparam int unsigned GW       = (START_GAP > 1) ? $clog2(START_GAP) : 1;
    localparam int unsigned GAP_LOAD = (START_GAP > 0) ? START_GAP - 1 : 0;

    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_RSV    = 2'd1,
        SLOT_QUEUED = 2'd2,
        SLOT_RUN    = 2'd3
    } slot_e;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_GAP  = 2'd1,
        ENG_RUN  = 2'd2
    } eng_e;

    slot_e                      slot_q  [N_CONTEXT];
    slot_e                      slot_d  [N_CONTEXT];
    logic [CW-1:0]              owner_q [N_CONTEXT];
    logic [CW-1:0]              owner_d [N_CONTEXT];
    logic [XW-1:0]              wptr_q, wptr_d;
    logic [XW-1:0]              rptr_q;
    logic                       rsv_held_q, rsv_held_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic [PW-1:0]              pending_q, pending_d;
    logic                       acq_valid_q, acq_valid_d;
    logic                       acq_ok_q, acq_ok_d;
    logic [XW-1:0]              acq_ctx_q, acq_ctx_d;
    logic                       commit_err_q, commit_err_d;
    logic [N_CORES-1:0][N_EVT:0] evt_q, evt_d;

    eng_e                       eng_q;
    logic [GW-1:0]              gap_q;
    logic                       start_q;
    logic                       busy_q;

    logic acq_ok, commit_ok, expire, eng_launch, run_enter, done_acc;

    // Wrap is an explicit compare so that slot counts which are not a power of two work.
    function automatic logic [XW-1:0] next_ptr(input logic [XW-1:0] p);
        return (p == XW'(N_CONTEXT - 1)) ? '0 : p + XW'(1);
    endfunction

    // All decisions look at the registered state from the start of the cycle.
    assign acq_ok     = acq_i && !rsv_held_q && (slot_q[wptr_q] == SLOT_FREE);
    assign commit_ok  = commit_i && rsv_held_q && (commit_core_i == owner_q[wptr_q]);
    assign expire     = (RSV_TIMEOUT != 0) && rsv_held_q && !commit_ok && (tmo_q == TW'(1));
    assign eng_launch = (eng_q == ENG_IDLE) && (slot_q[rptr_q] == SLOT_QUEUED);
    assign run_enter  = (eng_launch && (START_GAP == 0)) || ((eng_q == ENG_GAP) && (gap_q == '0));
    assign done_acc   = done_i && (eng_q == ENG_RUN);

    always_comb begin
        slot_d       = slot_q;
        owner_d      = owner_q;
        wptr_d       = wptr_q;
        rsv_held_d   = rsv_held_q;
        tmo_d        = tmo_q;

        // Grant needs no reservation held, while commit and expiry need one, so the three are exclusive.
        if (acq_ok) begin
            slot_d[wptr_q]  = SLOT_RSV;
            owner_d[wptr_q] = acq_core_i;
            rsv_held_d      = 1'b1;
            tmo_d           = TW'(RSV_TIMEOUT);
        end else if (commit_ok) begin
            slot_d[wptr_q] = SLOT_QUEUED;
            wptr_d         = next_ptr(wptr_q);
            rsv_held_d     = 1'b0;
        end else if (expire) begin
            slot_d[wptr_q] = SLOT_FREE;
            rsv_held_d     = 1'b0;
        end else if (rsv_held_q && (RSV_TIMEOUT != 0)) begin
            tmo_d = tmo_q - TW'(1);
        end

        if (run_enter) slot_d[rptr_q] = SLOT_RUN;
        if (done_acc)  slot_d[rptr_q] = SLOT_FREE;

        pending_d    = pending_q + PW'(acq_ok) - PW'(done_acc) - PW'(expire);
        acq_valid_d  = acq_i;
        acq_ok_d     = acq_ok;
        acq_ctx_d    = acq_ok ? wptr_q : '0;
        commit_err_d = commit_i && !commit_ok;

        evt_d = '0;
        evt_d[owner_q[rptr_q]] = {evt_i & {N_EVT{busy_q}}, done_acc};

        // Soft clear overrides every other input, including a done in the same cycle.
        if (clear_i) begin
            for (int i = 0; i < N_CONTEXT; i++) begin
                slot_d[i]  = SLOT_FREE;
                owner_d[i] = '0;
            end
            wptr_d       = '0;
            rsv_held_d   = 1'b0;
            tmo_d        = '0;
            pending_d    = '0;
            acq_valid_d  = 1'b0;
            acq_ok_d     = 1'b0;
            acq_ctx_d    = '0;
            commit_err_d = 1'b0;
            evt_d        = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the owner table is reset along with the slot states so that event routing never indexes with X.
            for (int i = 0; i < N_CONTEXT; i++) begin
                slot_q[i]  <= SLOT_FREE;
                owner_q[i] <= '0;
            end
            wptr_q       <= '0;
            rsv_held_q   <= 1'b0;
            tmo_q        <= '0;
            pending_q    <= '0;
            acq_valid_q  <= 1'b0;
            acq_ok_q     <= 1'b0;
            acq_ctx_q    <= '0;
            commit_err_q <= 1'b0;
            evt_q        <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments only; all next-state math lives in always_comb.
            slot_q       <= slot_d;
            owner_q      <= owner_d;
            wptr_q       <= wptr_d;
            rsv_held_q   <= rsv_held_d;
            tmo_q        <= tmo_d;
            pending_q    <= pending_d;
            acq_valid_q  <= acq_valid_d;
            acq_ok_q     <= acq_ok_d;
            acq_ctx_q    <= acq_ctx_d;
            commit_err_q <= commit_err_d;
            evt_q        <= evt_d;
        end
    end

    // Engine sequencer: IDLE -> (GAP for START_GAP cycles) -> RUN -> IDLE on an accepted done.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            eng_q   <= ENG_IDLE;
            gap_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            rptr_q  <= '0;
        end else if (clear_i) begin
            eng_q   <= ENG_IDLE;
            gap_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            rptr_q  <= '0;
        end else begin
            start_q <= run_enter;
            case (eng_q)
                ENG_IDLE: begin
                    if (eng_launch) begin
                        busy_q <= 1'b1;
                        if (START_GAP == 0) begin
                            eng_q <= ENG_RUN;
                        end else begin
                            eng_q <= ENG_GAP;
                            gap_q <= GW'(GAP_LOAD);
                        end
                    end
                end
                ENG_GAP: begin
                    if (gap_q == '0) eng_q <= ENG_RUN;
                    else             gap_q <= gap_q - GW'(1);
                end
                ENG_RUN: begin
                    if (done_i) begin
                        eng_q  <= ENG_IDLE;
                        busy_q <= 1'b0;
                        rptr_q <= next_ptr(rptr_q);
                    end
                end
                default: eng_q <= ENG_IDLE;
            endcase
        end
    end

    assign acq_valid_o  = acq_valid_q;
    assign acq_ok_o     = acq_ok_q;
    assign acq_ctx_o    = acq_ctx_q;
    assign commit_err_o = commit_err_q;
    assign rsv_ctx_o    = wptr_q;
    assign rsv_held_o   = rsv_held_q;
    assign start_o      = start_q;
    assign run_ctx_o    = rptr_q;
    assign busy_o       = busy_q;
    assign evt_o        = evt_q;
    assign pending_o    = pending_q;
    assign full_o       = (pending_q == PW'(N_CONTEXT));

endmodule

// File: tb/tb_hwpe_ctrl_job_queue.sv
// Bench for hwpe_ctrl_job_queue: acquire responses and job start order are checked against scoreboards,
// and event routing, timeouts and clear are checked directly against expected constants.
module tb_hwpe_ctrl_job_queue;

    localparam int N_CORES     = 4;
    localparam int N_CONTEXT   = 3;
    localparam int N_EVT       = 4;
    localparam int RSV_TIMEOUT = 8;
    localparam int START_GAP   = 2;
    localparam int CW          = 2;
    localparam int XW          = 2;
    localparam int PW          = 2;
    localparam int EW          = N_CORES * (N_EVT + 1);

    logic                         clk = 1'b0;
    logic                         rst_i = 1'b1;
    logic                         clear_i = 1'b0;
    logic                         acq_i = 1'b0;
    logic [CW-1:0]                acq_core_i = '0;
    logic                         acq_valid_o, acq_ok_o;
    logic [XW-1:0]                acq_ctx_o;
    logic                         commit_i = 1'b0;
    logic [CW-1:0]                commit_core_i = '0;
    logic                         commit_err_o;
    logic [XW-1:0]                rsv_ctx_o;
    logic                         rsv_held_o, start_o, busy_o, full_o;
    logic [XW-1:0]                run_ctx_o;
    logic                         done_i = 1'b0;
    logic [N_EVT-1:0]             evt_i = '0;
    logic [N_CORES-1:0][N_EVT:0]  evt_o;
    logic [PW-1:0]                pending_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int starts = 0;
    int last_start_cyc = 0;
    int commit_cyc = 0;
    int done_cyc = 0;

    logic [XW:0]   acq_exp_q [$];
    logic [XW-1:0] job_q [$];
    logic [XW:0]   acq_e;
    logic [N_CORES-1:0][N_EVT:0] exp_evt;

    hwpe_ctrl_job_queue #(
        .N_CORES(N_CORES), .N_CONTEXT(N_CONTEXT), .N_EVT(N_EVT),
        .RSV_TIMEOUT(RSV_TIMEOUT), .START_GAP(START_GAP)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
        .acq_i(acq_i), .acq_core_i(acq_core_i),
        .acq_valid_o(acq_valid_o), .acq_ok_o(acq_ok_o), .acq_ctx_o(acq_ctx_o),
        .commit_i(commit_i), .commit_core_i(commit_core_i), .commit_err_o(commit_err_o),
        .rsv_ctx_o(rsv_ctx_o), .rsv_held_o(rsv_held_o),
        .start_o(start_o), .run_ctx_o(run_ctx_o), .busy_o(busy_o),
        .done_i(done_i), .evt_i(evt_i), .evt_o(evt_o),
        .pending_o(pending_o), .full_o(full_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampled 1 time unit after the edge, ahead of the stimulus thread.
    always @(posedge clk) begin
        #1;
        if (acq_valid_o) begin
            if (acq_exp_q.size() == 0) begin
                check("acq_unexpected", 1, 0);
            end else begin
                acq_e = acq_exp_q.pop_front();
                check("acq_ok", 32'(acq_ok_o), 32'(acq_e[XW]));
                check("acq_ctx", 32'(acq_ctx_o), 32'(acq_e[XW-1:0]));
            end
        end
        if (start_o) begin
            starts++;
            last_start_cyc = cyc;
            if (job_q.size() == 0) check("start_unexpected", 1, 0);
            else                   check("run_ctx", 32'(run_ctx_o), 32'(job_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic acquire(input int core, input logic ok, input int ctx);
        acq_exp_q.push_back({ok, XW'(ctx)});
        acq_i = 1'b1;
        acq_core_i = CW'(core);
        step();
        acq_i = 1'b0;
    endtask

    task automatic commit(input int core, input logic ok, input int ctx);
        if (ok) job_q.push_back(XW'(ctx));
        commit_i = 1'b1;
        commit_core_i = CW'(core);
        step();
        commit_cyc = cyc;
        commit_i = 1'b0;
        check("commit_err", 32'(commit_err_o), 32'(!ok));
    endtask

    task automatic wait_starts(input int n);
        int k = 0;
        while (starts < n && k < 40) begin
            step();
            k++;
        end
        check("start_count", starts, n);
    endtask

    function automatic logic [EW-1:0] done_vec(input int core);
        logic [N_CORES-1:0][N_EVT:0] v;
        v = '0;
        v[core][0] = 1'b1;
        return v;
    endfunction

    task automatic finish_job(input int core, input int n_start);
        wait_starts(n_start);
        done_i = 1'b1;
        step();
        done_cyc = cyc;
        done_i = 1'b0;
        check("evt_done", 32'(evt_o), 32'(done_vec(core)));
    endtask

    function automatic logic [31:0] outs();
        return 32'({acq_valid_o, acq_ok_o, acq_ctx_o, commit_err_o, rsv_ctx_o, rsv_held_o,
                    start_o, run_ctx_o, busy_o, pending_o, full_o});
    endfunction

    initial begin
        #3;
        check("rst_outs", outs(), 0);
        check("rst_evt", 32'(evt_o), 0);
        step();
        step();
        rst_i = 1'b0;

        // Spurious done straight after reset.
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        check("spur_busy", 32'(busy_o), 0);
        check("spur_evt", 32'(evt_o), 0);

        // Single job from core 2.
        acquire(2, 1'b1, 0);
        check("t1_held", 32'(rsv_held_o), 1);
        check("t1_pend", 32'(pending_o), 1);
        commit(2, 1'b1, 0);
        check("t1_held_drop", 32'(rsv_held_o), 0);
        wait_starts(1);
        check("t1_start_lat", last_start_cyc - commit_cyc, START_GAP + 1);
        step();
        check("t1_start_pulse", 32'(start_o), 0);
        check("t1_busy", 32'(busy_o), 1);
        finish_job(2, 1);
        check("t1_pend_end", 32'(pending_o), 0);
        check("t1_busy_end", 32'(busy_o), 0);
        step();
        check("t1_evt_pulse", 32'(evt_o), 0);

        // Fill all slots from a clean state, then wrap.
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("t2_clr_outs", outs(), 0);
        acquire(0, 1'b1, 0);
        commit(0, 1'b1, 0);
        acquire(1, 1'b1, 1);
        commit(1, 1'b1, 1);
        acquire(3, 1'b1, 2);
        commit(3, 1'b1, 2);
        check("t2_pend", 32'(pending_o), 3);
        check("t2_full", 32'(full_o), 1);
        acquire(0, 1'b0, 0);
        check("t2_refused_held", 32'(rsv_held_o), 0);
        wait_starts(2);
        acq_exp_q.push_back({1'b0, XW'(0)});
        done_i = 1'b1;
        acq_i = 1'b1;
        acq_core_i = CW'(2);
        step();
        done_cyc = cyc;
        done_i = 1'b0;
        acq_i = 1'b0;
        check("t2_evt_done", 32'(evt_o), 32'(done_vec(0)));
        check("t2_full_drop", 32'(full_o), 0);
        acquire(1, 1'b1, 0);

        // Ownership: core 3 may not commit core 1's reservation.
        commit(3, 1'b0, 0);
        check("t3_held", 32'(rsv_held_o), 1);
        check("t3_rsv_ctx", 32'(rsv_ctx_o), 0);
        check("t3_pend", 32'(pending_o), 3);
        commit(1, 1'b1, 0);
        wait_starts(3);
        check("t2_b2b_lat", last_start_cyc - done_cyc, START_GAP + 1);
        finish_job(1, 3);
        finish_job(3, 4);
        finish_job(1, 5);
        check("t2_pend_end", 32'(pending_o), 0);

        // Done at idle and during GAP is ignored; events follow the running job's owner.
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        check("t5_idle_done_evt", 32'(evt_o), 0);
        check("t5_idle_done_pend", 32'(pending_o), 0);
        acquire(0, 1'b1, 1);
        commit(0, 1'b1, 1);
        step();
        check("t5_gap_busy", 32'(busy_o), 1);
        check("t5_gap_start", 32'(start_o), 0);
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        check("t5_gap_done_evt", 32'(evt_o), 0);
        check("t5_gap_done_busy", 32'(busy_o), 1);
        wait_starts(6);
        check("t5_start_lat", last_start_cyc - commit_cyc, START_GAP + 1);
        evt_i = 4'b0101;
        step();
        evt_i = '0;
        exp_evt = '0;
        exp_evt[0][N_EVT:1] = 4'b0101;
        check("t5_evt_fwd", 32'(evt_o), 32'(exp_evt));
        finish_job(0, 6);

        // Reservation timeout, then commit exactly in the expiry cycle.
        acquire(2, 1'b1, 2);
        for (int i = 1; i < RSV_TIMEOUT; i++) begin
            step();
            check("t4_still_held", 32'(rsv_held_o), 1);
        end
        step();
        check("t4_expired", 32'(rsv_held_o), 0);
        check("t4_pend", 32'(pending_o), 0);
        check("t4_wptr", 32'(rsv_ctx_o), 2);
        acquire(2, 1'b1, 2);
        repeat (RSV_TIMEOUT - 1) step();
        commit(2, 1'b1, 2);
        check("t4_commit_held", 32'(rsv_held_o), 0);
        check("t4_commit_pend", 32'(pending_o), 1);
        check("t4_commit_wptr", 32'(rsv_ctx_o), 0);
        finish_job(2, 7);

        // Clear while one job runs and two are queued.
        acquire(0, 1'b1, 0);
        commit(0, 1'b1, 0);
        acquire(1, 1'b1, 1);
        commit(1, 1'b1, 1);
        acquire(2, 1'b1, 2);
        commit(2, 1'b1, 2);
        wait_starts(8);
        check("t6_busy", 32'(busy_o), 1);
        clear_i = 1'b1;
        done_i = 1'b1;
        step();
        clear_i = 1'b0;
        done_i = 1'b0;
        job_q.delete();
        check("t6_clr_outs", outs(), 0);
        check("t6_clr_evt", 32'(evt_o), 0);
        repeat (10) step();
        check("t6_no_start", starts, 8);
        acquire(3, 1'b1, 0);
        step();
        check("acq_q_left", acq_exp_q.size(), 0);
        check("job_q_left", job_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required finish earlier", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hwpe_ctrl_job_queue.md
Name: hwpe_ctrl_job_queue

Overview:
- Parametrised multi-context job dispatcher for HWPE control. Sits between the peripheral-side register decode and the engine.
- Cores reserve a context slot, program it, then commit it. Committed jobs run on the engine in FIFO order with a start/done handshake.
- Completion and engine events are routed to the core that committed each job.
- Generalises the fixed two-context scheme in four ways:
  - any context count, including non-power-of-two;
  - reservation ownership check;
  - reservation timeout;
  - explicit error signalling.

Parameters:
- N_CORES, 4, number of requesting cores (>=1).
- N_CONTEXT, 3, number of job slots (>=1, any value).
- N_EVT, 4, engine event lines (>=1), routed as evt_o bits [N_EVT:1].
- RSV_TIMEOUT, 256, cycles a reservation may stay uncommitted before auto-release. 0 disables the timeout.
- START_GAP, 1, idle cycles between slot selection and start_o (>=0).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- clear_i  in  1  synchronous soft clear; same effect as reset.
- acq_i  in  1  reserve request (one-cycle pulse).
- acq_core_i  in  CW=max(1,$clog2(N_CORES))  requesting core id.
- acq_valid_o  out  1  acquire response valid.
- acq_ok_o  out  1  reservation granted.
- acq_ctx_o  out  XW=max(1,$clog2(N_CONTEXT))  reserved slot index.
- commit_i  in  1  commit request.
- commit_core_i  in  CW  committing core id.
- commit_err_o  out  1  commit rejected.
- rsv_ctx_o  out  XW  slot currently being programmed (write target for the regfile).
- rsv_held_o  out  1  reservation outstanding.
- start_o  out  1  engine start pulse.
- run_ctx_o  out  XW  slot of the running job.
- busy_o  out  1  engine job in flight.
- done_i  in  1  engine done pulse.
- evt_i  in  N_EVT  engine events.
- evt_o  out  N_CORES x (N_EVT+1)  per-core events; bit 0 is job done.
- pending_o  out  PW=$clog2(N_CONTEXT+1)  slots reserved, queued or running.
- full_o  out  1  pending_o == N_CONTEXT.

Behaviour:
- **Reset/clear:** every output and internal register is 0.
  - Slot states FREE; wptr = rptr = 0; no reservation; engine FSM IDLE.
  - clear_i takes priority over every other input in the same cycle.
- **Slot state:** each slot is FREE, RSV, QUEUED or RUN.
- **Pointers:** wptr and rptr count 0..N_CONTEXT-1 and wrap from N_CONTEXT-1 to 0 with an explicit compare, never by natural overflow.
- **Acquire:** evaluated on the registered state at the start of the cycle.
  - Granted iff no reservation is held and slot[wptr] is FREE.
  - On grant: slot[wptr] goes to RSV; owner[wptr] = acq_core_i; rsv_held_o = 1; timeout counter loads RSV_TIMEOUT.
  - Response is registered: 1 cycle later, acq_valid_o = 1 for one cycle, with acq_ok_o and acq_ctx_o = the granted slot (0 when refused).
- **Commit:**
  - Accepted iff rsv_held_o = 1 and commit_core_i == owner[wptr]. Then slot[wptr] goes to QUEUED, wptr advances, the reservation is dropped.
  - Otherwise there is no state change and commit_err_o pulses for one cycle, 1 cycle later.
  - acq_i and commit_i in the same cycle: commit is processed; acquire is refused because a reservation was held at cycle start.
- **Timeout:** while a reservation is held and RSV_TIMEOUT > 0, the counter decrements each cycle.
  - When it reaches 0 with no commit that cycle, the slot returns to FREE, the reservation is dropped, and wptr is unchanged.
  - A commit in the same cycle as expiry wins.
- **Engine FSM:** IDLE -> GAP -> RUN.
  - IDLE -> GAP when slot[rptr] is QUEUED. GAP lasts START_GAP cycles; START_GAP = 0 skips GAP.
  - Entering RUN: start_o pulses for exactly one cycle; slot[rptr] goes to RUN; busy_o is 1 from leaving IDLE until the cycle after done.
  - done_i is accepted only in RUN. Then slot[rptr] goes to FREE, rptr advances, and the FSM returns to IDLE.
  - done_i outside RUN is ignored, including a spurious done right after reset.
  - Back-to-back jobs: next start_o occurs START_GAP+1 cycles after done.
- **Events:** registered, 1-cycle latency.
  - evt_o[owner[rptr]][0] = accepted done.
  - evt_o[owner[rptr]][N_EVT:1] = evt_i while busy_o.
  - All other cores' bits are 0.
- **Counters:** pending_o is incremented on acquire grant and decremented on accepted done or timeout release; simultaneous inc/dec leaves it unchanged.
  - Never overflows: grants are impossible when full.
- **Mid-operation clear:** the running job is abandoned; no done event is produced for it.

Test Plan:
- N_CONTEXT=3: core 2 acquires -> acq_ok_o=1, acq_ctx_o=0; commits -> start_o exactly START_GAP+1 cycles after commit; done_i -> evt_o[2][0]=1 one cycle later, pending_o back to 0.
- Fill all 3 slots with engine stalled -> full_o=1; 4th acquire -> acq_ok_o=0. Then done_i plus acquire in the same cycle -> acquire refused, next-cycle acquire granted on slot 0 (wrap-around).
- Core 1 reserves, core 3 commits -> commit_err_o=1, slot stays RSV; core 1 commit succeeds.
- RSV_TIMEOUT=8: reserve, no commit -> slot FREE and rsv_held_o=0 after 8 cycles, pending_o back to 0, wptr unchanged. Commit in the expiry cycle -> job queued.
- done_i asserted at idle and in GAP -> ignored; evt_i=4'b0101 during the job of core 0 -> evt_o[0][4:1]=4'b0101, other cores 0.
- clear_i mid-RUN with 2 queued jobs -> all outputs 0 next cycle, no start_o afterwards, fresh acquire gets slot 0.
